uart_tx_drain: RTL and testbench
================================

Name: uart_tx_drain

Overview:
- Downstream consumer of the write queue filled by the data-collection controller (tag byte, then payload bytes).
- Pops one byte at a time from the queue head and serializes it onto the host UART line, 8 data bits, LSB first, no flow control.
- Sits between the write queue and the TX pin. It is the only reader of that queue.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200); legal range is 2 or more.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_write  in  8  head-of-queue byte; valid whenever em_write is low.
- em_write  in  1  queue empty flag.
- pp_write  out  1  pop strobe; one clk wide; the queue advances on the edge after it is high.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high from the start bit through the last stop bit.

Behaviour:
- Reset, sampled on the clk edge: tx=1, pp_write=0, busy=0, state=IDLE, bit/baud counters=0, shift register=0.
- Reset mid-frame: tx returns high on the next edge; the frame is aborted; the popped byte is lost. It is not re-popped.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - Edge with em_write=0: capture in_write into the shift register, set pp_write=1, tx=0, busy=1, baud count=0, go to START.
  - em_write=1: hold with tx=1.
- pp_write is forced to 0 on the following edge. It is therefore high for exactly one cycle, coincident with the first start-bit cycle.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right.
  - After bit index 7 go to PARITY if that feature is compiled in, otherwise to STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle: busy=0, go to IDLE.
- Back-to-back bytes: IDLE is occupied for exactly one cycle. The next start bit falls one clk after the last stop-bit cycle.
- Frame length in clk: (10 + STOP_BITS - 1 [+1 parity]) * CLKS_PER_BIT, plus 1 idle cycle between frames.
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT*STOP_BITS). It wraps to 0 at each bit boundary; there is no free-running drift.
  - Bit index width is 3 bits.
- em_write is sampled only in IDLE. Changes to em_write or in_write during a frame are ignored.
- in_write must be stable in the capture cycle. The queue's show-ahead guarantees this.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA.
  - tx = even parity (XOR of the 8 captured bits) for CLKS_PER_BIT cycles.
  - Frame grows by one bit.
- Undefined: no PARITY state. DATA goes directly to STOP and no parity logic is synthesized.

Decomposition:
- Shared package vdas_pkg holds:
  - The TX state encoding (IDLE, START, DATA, PARITY, STOP).
  - UART_DATA_W=8.
  - The source tag constants (DIN, ADC0, ADC1, CADC0, CADC1 = 1..5), so benches can decode frames.
- One natural sub-module, uart_baud_tick:
  - Counter with a restart input and a one-cycle tick output at CLKS_PER_BIT.
  - Reused later by the RX path.

Test Plan (CLKS_PER_BIT=4, STOP_BITS=1 unless stated):
- Reset idle: rst high for 3 cycles, queue empty -> tx=1, busy=0, pp_write=0 throughout; no pop for 100 cycles.
- Single byte: queue holds 0xA5 ->
  - pp_write high for 1 cycle.
  - tx sequence per 4-clk bit: 0,1,0,1,0,0,1,0,1,1.
  - busy low after 40 clk.
- Back-to-back: queue holds 0x02 (ADC0 tag), 0x34, 0x03 ->
  - three frames, three pops.
  - Exactly 1 clk of tx=1 idle between each stop bit and the next start bit.
  - Decoded bytes 0x02, 0x34, 0x03.
- Reset mid-frame: assert rst during DATA bit 3 of 0xFF ->
  - tx=1 the next cycle, busy=0.
  - Queue popped once only.
  - The next byte 0x5A after release transmits cleanly.
- STOP_BITS=2, CLKS_PER_BIT=2, byte 0x00 -> tx low for 18 clk, high for 4 clk, then idle.
- UART_TX_PARITY_EN defined:
  - 0xA5 -> parity bit 0.
  - 0x07 -> parity bit 1.
  - Frame is 44 clk at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/vdas_pkg.sv
// Shared definitions for the data-collection path: UART TX state encoding,
// data width, and the source tag bytes that lead each record in the write queue.
package vdas_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    localparam logic [7:0] TAG_DIN   = 8'd1;
    localparam logic [7:0] TAG_ADC0  = 8'd2;
    localparam logic [7:0] TAG_ADC1  = 8'd3;
    localparam logic [7:0] TAG_CADC0 = 8'd4;
    localparam logic [7:0] TAG_CADC1 = 8'd5;

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: ticks on the last cycle of each period and wraps to 0.
// long_i stretches the period to MAX_BITS bit times (used for multi-bit stop).
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 104,
    parameter int MAX_BITS     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic long_i,
    output logic tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT * MAX_BITS > 1) ? $clog2(CLKS_PER_BIT * MAX_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_SHORT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_LONG  = CNT_W'(CLKS_PER_BIT * MAX_BITS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last;

    assign last   = long_i ? LAST_LONG : LAST_SHORT;
    assign tick_o = !restart_i && (cnt_q == last);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from the write queue head and sends them as 8N1 UART frames.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx_drain
    import vdas_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] in_write,
    input  logic                   em_write,
    output logic                   pp_write,
    output logic                   tx,
    output logic                   busy
);

    tx_state_t              state_q, state_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [2:0]             bit_q, bit_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   pp_q, pp_d;
    logic                   tick;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    // Counter is held at zero in IDLE so every frame starts phase-aligned.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .MAX_BITS     (STOP_BITS)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .restart_i (state_q == TX_IDLE),
        .long_i    (state_q == TX_STOP),
        .tick_o    (tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        pp_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            TX_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!em_write) begin
                    shift_d = in_write;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(in_write);
`endif
                    pp_d    = 1'b1;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = TX_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
`endif
                    end else begin
                        // Drive the next bit on the same edge the register shifts.
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = TX_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= TX_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            pp_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            pp_q     <= pp_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign pp_write = pp_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: a table of single-byte frames plus
// back-to-back, mid-frame reset and two-stop-bit sequences.
module tb_uart_tx_drain;
    import vdas_pkg::*;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB   = 11;
    localparam int LOW2 = 20;
`else
    localparam int NB   = 10;
    localparam int LOW2 = 18;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_write = 8'h00;
    logic       em_write = 1'b1;
    logic       pp_write, tx, busy;
    logic [7:0] in2 = 8'h00;
    logic       em2 = 1'b1;
    logic       pp2, tx2, busy2;

    int         n_pass = 0;
    int         n_total = 0;
    int         pops = 0;
    int         pops2 = 0;
    logic [7:0] q[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit i = i-th transmitted bit (start..stop)
        logic       par;
    } vec_t;

    vec_t vecs[5];
    vec_t b2b[3];

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .in_write(in_write), .em_write(em_write),
        .pp_write(pp_write), .tx(tx), .busy(busy)
    );

    uart_tx_drain #(.CLKS_PER_BIT(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .in_write(in2), .em_write(em2),
        .pp_write(pp2), .tx(tx2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Show-ahead queue model: pops one entry per pop strobe.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pp_write) begin
                if (q.size() > 0) void'(q.pop_front());
                pops++;
            end
            if (pp2) pops2++;
            if (q.size() > 0) begin
                em_write = 1'b0;
                in_write = q[0];
            end else begin
                em_write = 1'b1;
                in_write = 8'h00;
            end
        end
    end

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_w(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [10:0] exp_bits(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return {1'b1, v.par, v.frame[8:1], 1'b0};
`else
        return {1'b0, v.frame};
`endif
    endfunction

    function automatic logic [63:0] expand(input logic [10:0] b);
        logic [63:0] w;
        w = '0;
        for (int c = 0; c < FRAME; c++) w[c] = b[c / CPB];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pp_write) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    // Entered on the first start-bit cycle; leaves on the cycle after the frame.
    task automatic run_frame(input vec_t v, input string tag);
        logic [63:0] w;
        logic [7:0]  d;
        int          busy_lo;
        int          pp_hi;
        w = '0;
        busy_lo = 0;
        pp_hi = 0;
        for (int c = 0; c < FRAME; c++) begin
            w[c] = tx;
            if (!busy) busy_lo++;
            if (pp_write) pp_hi++;
            step();
        end
        for (int j = 0; j < 8; j++) d[j] = w[(1 + j) * CPB + CPB / 2];
        $display("%s frame: expected %02h decoded %02h", tag, v.data, d);
        chk_w({tag, "_wave"}, w, expand(exp_bits(v)));
        chk_i({tag, "_byte"}, int'(d), int'(v.data));
        chk_i({tag, "_busy_gaps"}, busy_lo, 0);
        chk_i({tag, "_pop_cycles"}, pp_hi, 1);
    endtask

    initial begin
        bit ok;
        int p0;
        int bad;
        int low;
        int hi;

        vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
        vecs[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
        vecs[2] = '{8'h00, 10'b1_00000000_0, 1'b0};
        vecs[3] = '{8'hFF, 10'b1_11111111_0, 1'b0};
        vecs[4] = '{8'h5A, 10'b1_01011010_0, 1'b0};
        b2b[0]  = '{TAG_ADC0, 10'b1_00000010_0, 1'b1};
        b2b[1]  = '{8'h34,    10'b1_00110100_0, 1'b1};
        b2b[2]  = '{TAG_ADC1, 10'b1_00000011_0, 1'b0};

        // Reset held three cycles with an empty queue.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_b("rst_tx", tx, 1'b1);
            chk_b("rst_busy", busy, 1'b0);
            chk_b("rst_pp", pp_write, 1'b0);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0 || pp_write !== 1'b0) bad++;
        end
        chk_i("idle_bad_cycles", bad, 0);
        chk_i("idle_pops", pops, 0);

        // Single-byte table.
        for (int i = 0; i < 5; i++) begin
            p0 = pops;
            q.push_back(vecs[i].data);
            wait_pp(ok);
            chk_b("single_pop_seen", ok, 1'b1);
            if (ok) begin
                run_frame(vecs[i], "single");
                chk_b("single_end_tx", tx, 1'b1);
                chk_b("single_end_busy", busy, 1'b0);
                chk_i("single_pops", pops, p0 + 1);
            end
            repeat (3) step();
        end

        // Back-to-back: one idle cycle between stop and next start.
        p0 = pops;
        for (int i = 0; i < 3; i++) q.push_back(b2b[i].data);
        wait_pp(ok);
        chk_b("b2b_pop_seen", ok, 1'b1);
        if (ok) begin
            for (int k = 0; k < 3; k++) begin
                run_frame(b2b[k], "b2b");
                chk_b("b2b_gap_tx", tx, 1'b1);
                chk_b("b2b_gap_busy", busy, 1'b0);
                chk_b("b2b_gap_pp", pp_write, 1'b0);
                if (k < 2) begin
                    step();
                    chk_b("b2b_next_pp", pp_write, 1'b1);
                    chk_b("b2b_next_start", tx, 1'b0);
                end
            end
            chk_i("b2b_pops", pops, p0 + 3);
        end
        repeat (5) step();

        // Reset during data bit 3 of 0xFF.
        p0 = pops;
        q.push_back(8'hFF);
        wait_pp(ok);
        chk_b("abort_pop_seen", ok, 1'b1);
        repeat (17) step();
        chk_b("abort_bit3_tx", tx, 1'b1);
        chk_b("abort_bit3_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        chk_b("abort_tx", tx, 1'b1);
        chk_b("abort_busy", busy, 1'b0);
        chk_b("abort_pp", pp_write, 1'b0);
        rst = 1'b0;
        repeat (20) step();
        chk_i("abort_pops", pops, p0 + 1);
        chk_b("abort_no_resend", busy, 1'b0);
        q.push_back(vecs[4].data);
        wait_pp(ok);
        chk_b("after_abort_pop_seen", ok, 1'b1);
        if (ok) run_frame(vecs[4], "after_abort");

        // Two stop bits at two clocks per bit, byte 0x00.
        em2 = 1'b0;
        in2 = 8'h00;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (pp2) ok = 1'b1;
            else step();
        end
        chk_b("stop2_pop_seen", ok, 1'b1);
        em2 = 1'b1;
        low = 0;
        while (tx2 === 1'b0 && low < 100) begin
            low++;
            step();
        end
        hi = 0;
        while (busy2 === 1'b1 && hi < 100) begin
            if (tx2 !== 1'b1) bad++;
            hi++;
            step();
        end
        $display("stop2 frame: low %0d clk, stop %0d clk", low, hi);
        chk_i("stop2_low", low, LOW2);
        chk_i("stop2_high", hi, 4);
        chk_b("stop2_idle_tx", tx2, 1'b1);
        repeat (10) step();
        chk_b("stop2_stays_idle", busy2, 1'b0);
        chk_i("stop2_pops", pops2, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
